keypad_entry: RTL and testbench
===============================

# keypad_entry

Front-end of the digital lock. It takes raw keypad presses, synchronises and debounces them, then assembles four decimal digits into a 16-bit code word. On the Enter key it presents that word to the lock datapath/controlpath with a valid/ack handshake. It also handles Clear, inactivity timeout and malformed entries, so the lock core only ever sees complete 4-digit codes.

## Interface
- DEBOUNCE_CYCLES, 4: number of consecutive stable synchronised cycles required before a level change is accepted. Must be ≥2.
- TIMEOUT_CYCLES, 1000: idle cycles after the last accepted key before a partial entry is discarded. Must be ≥2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_press  input  1  raw, bouncy, asynchronous key-down level.
- key_code  input  4  key identity; stable whenever key_press is high. 0–9 are digits, 0xA is Clear, 0xB is Enter, 0xC–0xF are ignored.
- code_ack  input  1  lock consumed code_out (level, sampled on the clock).
- code_out  output  16  assembled code; first digit in [15:12], fourth digit in [3:0].
- code_valid  output  1  code_out holds a complete code awaiting ack.
- digit_count  output  3  digits currently buffered, 0–4.
- entry_err  output  1  one-cycle pulse flagging a bad entry or a timeout.

## Operation
- Input path:
  - key_press passes through a 2-flop synchroniser, giving ks.
  - key_code is captured through a matching 2-flop register.
- Debounce:
  - A counter increments while ks differs from the debounced level kd, and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, kd toggles and the counter clears.
  - A key event fires in the cycle kd goes 0→1. Release (kd 1→0) generates no event.
  - A new event needs kd to go low first, so a held key gives exactly one event.
- States:
  - ENTRY: collecting digits; reset state.
  - PRESENT: code_valid=1.
- In ENTRY, per key event:
  - Digit with digit_count<4: code_out ← {code_out[11:0], digit}, digit_count+1.
  - Digit with digit_count=4: ignored, no error.
  - Clear: code_out←0, digit_count←0, no error.
  - Enter with digit_count=4: go to PRESENT.
  - Enter with digit_count<4: entry_err pulse, buffer cleared, stay in ENTRY.
  - 0xC–0xF: ignored entirely; the timeout counter is not restarted.
- Timeout:
  - The idle counter clears on every accepted digit, Clear or Enter.
  - It counts only while in ENTRY with digit_count>0.
  - When it reaches TIMEOUT_CYCLES: entry_err pulse, buffer cleared.
- In PRESENT:
  - All key events are discarded.
  - code_out and digit_count are held stable.
  - The idle counter is frozen at 0.
  - When code_ack is high on an edge: return to ENTRY, code_out←0, digit_count←0.
- code_ack while in ENTRY is ignored.
- Reset (asynchronous, any state, including mid-entry or during PRESENT):
  - State ENTRY.
  - code_out=0, code_valid=0, digit_count=0, entry_err=0.
  - Synchronisers, kd, and both counters cleared.

## Timing
- Press latency: digit_count/code_out update DEBOUNCE_CYCLES+3 edges after the first edge sampling key_press high (bounce-free input).
- Bounce shorter than DEBOUNCE_CYCLES consecutive cycles on ks never produces an event.
- Handshake:
  - code_valid rises on the edge after the Enter event.
  - code_valid falls on the edge sampling code_ack=1.
  - Minimum code_valid width is 1 cycle, when code_ack is already high.
- entry_err is high for exactly one cycle, on the edge following the cause.
- Simultaneous timeout expiry and key event in the same cycle: the key event wins and the idle counter clears.
- The width rules are fixed:
  - digit_count saturates at 4.
  - Counter widths are sized to hold their parameter.
  - The idle counter does not wrap; it stops at expiry.

## Test plan
- Reset mid-entry: after 2 digits, assert rst_n=0 asynchronously -> all outputs 0 immediately, digit_count=0.
- Press 1,3,0,9, then Enter, with code_ack held low for 5 cycles then pulsed -> code_out=0x1309, code_valid high until the ack edge, then 0 with digit_count=0.
- key_press glitching high for 3 cycles (DEBOUNCE_CYCLES=4), then a clean press of 7 -> only one event; code_out=0x0007, digit_count=1.
- Press 1,2, then Enter -> entry_err single-cycle pulse, digit_count=0, code_valid stays 0. Then press 5,5,5,5,6 and Enter -> code_out=0x5555, with the 6 ignored.
- Press 4, then go idle for TIMEOUT_CYCLES (set to 20) -> entry_err pulse at expiry, digit_count=0. Also check that 0xE presses do not extend the timeout.
- In PRESENT, press 8 and Clear -> code_out unchanged. Then press 2,2,2,2, Enter, keeping code_ack high -> code_valid is high for exactly 1 cycle.

Source files
------------

// File: rtl/keypad_entry_if.sv
// Keypad-to-lock bundle: raw key inputs and ack in, assembled code and status out.
interface keypad_entry_if;
    logic        key_press;
    logic [3:0]  key_code;
    logic        code_ack;
    logic [15:0] code_out;
    logic        code_valid;
    logic [2:0]  digit_count;
    logic        entry_err;

    modport master (
        output key_press, key_code, code_ack,
        input  code_out, code_valid, digit_count, entry_err
    );

    modport slave (
        input  key_press, key_code, code_ack,
        output code_out, code_valid, digit_count, entry_err
    );
endinterface

// File: rtl/keypad_entry.sv
// Keypad front-end: sync, debounce, 4-digit assembly, Enter/Clear/timeout handling.
// Key effects land DEBOUNCE_CYCLES+3 edges after press; code_valid holds until code_ack.
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    keypad_entry_if.slave bus
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TOW-1:0] TO_MAX  = TOW'(TIMEOUT_CYCLES);

    typedef enum logic {ENTRY, PRESENT} state_t;

    logic           press_meta, ks, kd;
    logic [3:0]     code_meta, code_sync, evt_code;
    logic [DBW-1:0] db_cnt;
    logic           key_evt;

    state_t         state;
    logic [15:0]    code_q;
    logic [2:0]     count_q;
    logic           valid_q, err_q;
    logic [TOW-1:0] idle_cnt;

    logic is_digit, is_clear, is_enter, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_meta <= 1'b0;
            ks         <= 1'b0;
            code_meta  <= '0;
            code_sync  <= '0;
            kd         <= 1'b0;
            db_cnt     <= '0;
            key_evt    <= 1'b0;
            evt_code   <= '0;
        end else begin
            press_meta <= bus.key_press;
            ks         <= press_meta;
            code_meta  <= bus.key_code;
            code_sync  <= code_meta;
            key_evt    <= 1'b0;
            if (ks != kd) begin
                if (db_cnt == DB_LAST) begin
                    kd       <= ks;
                    db_cnt   <= '0;
                    // Only the rising edge of the debounced level is an event.
                    key_evt  <= ks;
                    evt_code <= code_sync;
                end else begin
                    db_cnt <= db_cnt + DBW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_comb begin
        is_digit = (evt_code <= 4'd9);
        is_clear = (evt_code == 4'hA);
        is_enter = (evt_code == 4'hB);
        // Ignored keys (0xC-0xF, fifth digit) must not disturb the idle timer.
        accept   = key_evt && ((is_digit && count_q != 3'd4) || is_clear || is_enter);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ENTRY;
            code_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            idle_cnt <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ENTRY: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (is_digit) begin
                            code_q  <= {code_q[11:0], evt_code};
                            count_q <= count_q + 3'd1;
                        end else if (is_clear) begin
                            code_q  <= '0;
                            count_q <= '0;
                        end else if (count_q == 3'd4) begin
                            state   <= PRESENT;
                            valid_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b1;
                            code_q  <= '0;
                            count_q <= '0;
                        end
                    end else if (count_q != 3'd0) begin
                        if (idle_cnt == TO_MAX) begin
                            err_q    <= 1'b1;
                            code_q   <= '0;
                            count_q  <= '0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + TOW'(1);
                        end
                    end
                end
                PRESENT: begin
                    idle_cnt <= '0;
                    if (bus.code_ack) begin
                        state   <= ENTRY;
                        valid_q <= 1'b0;
                        code_q  <= '0;
                        count_q <= '0;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

    assign bus.code_out    = code_q;
    assign bus.code_valid  = valid_q;
    assign bus.digit_count = count_q;
    assign bus.entry_err   = err_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_keypad_entry;
    localparam int DB = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   upd_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypad_entry_if bus();

    keypad_entry #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clean press held for exactly DB samples; returns just before the update edge.
    task automatic key_tap(input logic [3:0] k);
        @(negedge clk);
        bus.key_press = 1'b1;
        bus.key_code  = k;
        repeat (DB) @(posedge clk);
        @(negedge clk);
        bus.key_press = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Lets the released key debounce low before the next press.
    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] k);
        key_tap(k);
        @(posedge clk);
        #1;
        upd_cyc = cyc;
        settle();
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.key_press = 1'b0;
        bus.key_code  = 4'h0;
        bus.code_ack  = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++; if (bus.code_out !== 16'h0) begin errors++; $display("FAIL reset_code got %h want 0000", bus.code_out); end
        checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.code_valid); end
        checks++; if (bus.digit_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.digit_count); end
        checks++; if (bus.entry_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.entry_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        press_key(4'd1);
        press_key(4'd2);
        checks++; if (bus.digit_count !== 3'd2) begin errors++; $display("FAIL mid_pre_count got %0d want 2", bus.digit_count); end
        checks++; if (bus.code_out !== 16'h0012) begin errors++; $display("FAIL mid_pre_code got %h want 0012", bus.code_out); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.digit_count !== 3'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", bus.digit_count); end
        checks++; if (bus.code_out !== 16'h0) begin errors++; $display("FAIL mid_rst_code got %h want 0000", bus.code_out); end
        checks++; if (bus.code_valid !== 1'b0 || bus.entry_err !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got %b%b want 00", bus.code_valid, bus.entry_err); end
        @(negedge clk);
        rst_n = 1'b1;
        press_key(4'd6);
        checks++; if (bus.code_out !== 16'h0006 || bus.digit_count !== 3'd1) begin errors++; $display("FAIL mid_after got %h/%0d want 0006/1", bus.code_out, bus.digit_count); end
        press_key(4'hA);
    endtask

    task automatic test_entry_1309();
        key_tap(4'd1);
        checks++; if (bus.digit_count !== 3'd0) begin errors++; $display("FAIL lat_early got %0d want 0", bus.digit_count); end
        @(posedge clk); #1;
        checks++; if (bus.digit_count !== 3'd1) begin errors++; $display("FAIL lat_update got %0d want 1", bus.digit_count); end
        settle();
        press_key(4'd3);
        press_key(4'd0);
        press_key(4'd9);
        checks++; if (bus.code_out !== 16'h1309) begin errors++; $display("FAIL e1309_code got %h want 1309", bus.code_out); end
        checks++; if (bus.digit_count !== 3'd4 || bus.code_valid !== 1'b0) begin errors++; $display("FAIL e1309_cnt got %0d/%b want 4/0", bus.digit_count, bus.code_valid); end
        key_tap(4'hB);
        checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL e1309_valid_early got %b want 0", bus.code_valid); end
        @(posedge clk); #1;
        checks++; if (bus.code_valid !== 1'b1 || bus.code_out !== 16'h1309) begin errors++; $display("FAIL e1309_present got %b/%h want 1/1309", bus.code_valid, bus.code_out); end
        repeat (5) begin
            @(posedge clk); #1;
            checks++; if (bus.code_valid !== 1'b1) begin errors++; $display("FAIL e1309_hold got %b want 1", bus.code_valid); end
        end
        @(negedge clk);
        bus.code_ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL e1309_ack_valid got %b want 0", bus.code_valid); end
        checks++; if (bus.digit_count !== 3'd0 || bus.code_out !== 16'h0) begin errors++; $display("FAIL e1309_ack_clr got %0d/%h want 0/0000", bus.digit_count, bus.code_out); end
        @(negedge clk);
        bus.code_ack = 1'b0;
    endtask

    task automatic test_glitch();
        @(negedge clk);
        bus.key_press = 1'b1;
        bus.key_code  = 4'd7;
        repeat (DB - 1) @(posedge clk);
        @(negedge clk);
        bus.key_press = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (bus.digit_count !== 3'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", bus.digit_count); end
        press_key(4'd7);
        checks++; if (bus.code_out !== 16'h0007 || bus.digit_count !== 3'd1) begin errors++; $display("FAIL glitch_press got %h/%0d want 0007/1", bus.code_out, bus.digit_count); end
        press_key(4'hA);
        checks++; if (bus.code_out !== 16'h0 || bus.digit_count !== 3'd0) begin errors++; $display("FAIL clear got %h/%0d want 0000/0", bus.code_out, bus.digit_count); end
    endtask

    task automatic test_short_enter();
        press_key(4'd1);
        press_key(4'd2);
        key_tap(4'hB);
        checks++; if (bus.entry_err !== 1'b0 || bus.digit_count !== 3'd2) begin errors++; $display("FAIL short_pre got %b/%0d want 0/2", bus.entry_err, bus.digit_count); end
        @(posedge clk); #1;
        checks++; if (bus.entry_err !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", bus.entry_err); end
        checks++; if (bus.digit_count !== 3'd0 || bus.code_valid !== 1'b0) begin errors++; $display("FAIL short_clr got %0d/%b want 0/0", bus.digit_count, bus.code_valid); end
        @(posedge clk); #1;
        checks++; if (bus.entry_err !== 1'b0) begin errors++; $display("FAIL short_err_width got %b want 0", bus.entry_err); end
        settle();
        press_key(4'd5);
        press_key(4'd5);
        press_key(4'd5);
        press_key(4'd5);
        press_key(4'd6);
        checks++; if (bus.code_out !== 16'h5555 || bus.digit_count !== 3'd4) begin errors++; $display("FAIL fifth_digit got %h/%0d want 5555/4", bus.code_out, bus.digit_count); end
        press_key(4'hB);
        checks++; if (bus.code_valid !== 1'b1 || bus.code_out !== 16'h5555) begin errors++; $display("FAIL e5555 got %b/%h want 1/5555", bus.code_valid, bus.code_out); end
        @(negedge clk);
        bus.code_ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL e5555_ack got %b want 0", bus.code_valid); end
        @(negedge clk);
        bus.code_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int t0;
        press_key(4'd4);
        t0 = upd_cyc;
        wait_to(t0 + TO);
        checks++; if (bus.digit_count !== 3'd1 || bus.entry_err !== 1'b0) begin errors++; $display("FAIL to_before got %0d/%b want 1/0", bus.digit_count, bus.entry_err); end
        @(posedge clk); #1;
        checks++; if (bus.entry_err !== 1'b1 || bus.digit_count !== 3'd0) begin errors++; $display("FAIL to_expire got %b/%0d want 1/0", bus.entry_err, bus.digit_count); end
        @(posedge clk); #1;
        checks++; if (bus.entry_err !== 1'b0) begin errors++; $display("FAIL to_width got %b want 0", bus.entry_err); end
        settle();
        press_key(4'd4);
        t0 = upd_cyc;
        press_key(4'hE);
        wait_to(t0 + TO);
        checks++; if (bus.digit_count !== 3'd1 || bus.entry_err !== 1'b0) begin errors++; $display("FAIL toE_before got %0d/%b want 1/0", bus.digit_count, bus.entry_err); end
        @(posedge clk); #1;
        checks++; if (bus.entry_err !== 1'b1 || bus.digit_count !== 3'd0) begin errors++; $display("FAIL toE_expire got %b/%0d want 1/0", bus.entry_err, bus.digit_count); end
        settle();
    endtask

    task automatic test_present_ignore();
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd4);
        press_key(4'hB);
        press_key(4'd8);
        press_key(4'hA);
        checks++; if (bus.code_out !== 16'h1234 || bus.digit_count !== 3'd4) begin errors++; $display("FAIL pres_hold got %h/%0d want 1234/4", bus.code_out, bus.digit_count); end
        checks++; if (bus.code_valid !== 1'b1) begin errors++; $display("FAIL pres_valid got %b want 1", bus.code_valid); end
        @(negedge clk);
        bus.code_ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.code_valid !== 1'b0 || bus.code_out !== 16'h0) begin errors++; $display("FAIL pres_ack got %b/%h want 0/0000", bus.code_valid, bus.code_out); end
        press_key(4'd2);
        press_key(4'd2);
        press_key(4'd2);
        press_key(4'd2);
        checks++; if (bus.code_out !== 16'h2222 || bus.code_valid !== 1'b0) begin errors++; $display("FAIL b2b_entry got %h/%b want 2222/0", bus.code_out, bus.code_valid); end
        key_tap(4'hB);
        @(posedge clk); #1;
        checks++; if (bus.code_valid !== 1'b1 || bus.code_out !== 16'h2222) begin errors++; $display("FAIL b2b_rise got %b/%h want 1/2222", bus.code_valid, bus.code_out); end
        @(posedge clk); #1;
        checks++; if (bus.code_valid !== 1'b0 || bus.digit_count !== 3'd0) begin errors++; $display("FAIL b2b_fall got %b/%0d want 0/0", bus.code_valid, bus.digit_count); end
        @(negedge clk);
        bus.code_ack = 1'b0;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_entry_1309();
        test_reset_mid();
        test_glitch();
        test_short_enter();
        test_timeout();
        test_present_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
